// File: rtl/demux_pkg.sv
// demux_pkg: shared lane-count and select constants for the demux slice
package demux_pkg;
   localparam int N_OUT = 8;
   localparam int SEL_W = 3;
   typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux1_8_dec3to8.sv
// dec3to8: binary-to-one-hot decoder with enable
module dec3to8
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [N_OUT-1:0] onehot
);
   assign onehot = en ? {{(N_OUT-1){1'b0}}, 1'b1} << sel : '0;
endmodule

// File: rtl/demux1_8.sv
// demux1_8: registered 1-to-8 demultiplexer, steers D to lane S when E is high
module demux1_8
   import demux_pkg::*;
#(
   parameter int DATA_W = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_W-1:0]       D,
   input  logic [SEL_W-1:0]        S,
   input  logic                    E,
   output logic [N_OUT*DATA_W-1:0] I
);
   logic [N_OUT-1:0]        onehot;
   logic [N_OUT*DATA_W-1:0] lanes;
   dec3to8 u_dec (
      .sel    (S),
      .en     (E),
      .onehot (onehot)
   );
   for (genvar g = 0; g < N_OUT; g++) begin : g_lane
      assign lanes[g*DATA_W +: DATA_W] = D & {DATA_W{onehot[g]}};
   end
   // every edge rewrites all lanes, so unselected lanes never keep stale data
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) I <= '0;
      else        I <= lanes;
endmodule

// File: tb/tb_demux1_8.sv
// tb_demux1_8: directed self-checking bench for demux1_8
module tb_demux1_8;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [0:0] D = 1'b1;
   logic [2:0] S = 3'd5;
   logic       E = 1'b1;
   logic [7:0] I;
   int checks = 0;
   int errors = 0;
   logic [7:0] sweep [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

   demux1_8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .D     (D),
      .S     (S),
      .E     (E),
      .I     (I)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic d, input logic [2:0] s, input logic e, input logic [7:0] exp, input string tag);
      @(negedge clk);
      D = d;
      S = s;
      E = e;
      @(posedge clk);
      #1;
      check(tag, I, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      #1 rst_n = 1'b0;
      #1 check("rst_async", I, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("rst_hold", I, 8'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("rst_release", I, 8'h20);
      cyc(1'b1, 3'd0, 1'b0, 8'h00, "disabled0");
      cyc(1'b1, 3'd0, 1'b0, 8'h00, "disabled1");
      for (int s = 0; s < 8; s++) begin
         cyc(1'b1, 3'(s), 1'b1, sweep[s], $sformatf("sweep%0d", s));
         check($sformatf("onehot%0d", s), 8'($countones(I)), 8'd1);
      end
      @(negedge clk);
      S = 3'd2;
      #1 check("no_comb_path", I, 8'h80);
      cyc(1'b1, 3'd3, 1'b1, 8'h08, "zero_pre");
      cyc(1'b0, 3'd3, 1'b1, 8'h00, "zero_data");
      cyc(1'b1, 3'd7, 1'b1, 8'h80, "en_pre");
      cyc(1'b1, 3'd7, 1'b0, 8'h00, "en_drop");
      cyc(1'b1, 3'd7, 1'b1, 8'h80, "en_raise");
      cyc(1'b1, 3'd4, 1'b1, 8'h10, "mid_pre");
      #2 rst_n = 1'b0;
      #1 check("mid_rst_async", I, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("mid_rst_restore", I, 8'h10);
      cyc(1'b1, 3'd5, 1'b1, 8'h20, "post_rst");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux1_8.md
Name: demux1_8

Overview:
- Registered 1-to-8 demultiplexer with enable.
- Routes the data input D to the single output lane selected by S. All other lanes are driven to 0.
- Used as a small steering element wherever one serial/control bit must fan out to one of eight destinations.
- Outputs are registered on the clock for clean timing at block boundaries.

Parameters:
- DATA_W, default 1, width of D and of each output lane (lane k occupies I[k*DATA_W +: DATA_W]).
- N_OUT, default 8, number of output lanes. Fixed at 8 for this block; not overridable.
- SEL_W, default 3, width of S. Fixed at log2(N_OUT) = 3.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- D  input  DATA_W  data to be steered.
- S  input  3  lane select, binary 0..7.
- E  input  1  enable, active-high.
- I  output  8*DATA_W  output lanes. Lane k = I[k*DATA_W +: DATA_W]. With DATA_W=1, I[k] is lane k.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset:
  - rst_n=0 forces I to all zeros immediately, independent of clk.
  - I holds zero while rst_n is low.
  - On release, the first update occurs at the next rising clk edge.
- Latency: exactly 1 clock. I at edge n+1 reflects D/S/E sampled at edge n. There is no combinational path from inputs to I.
- Enabled (E=1): at each rising edge:
  - lane S is loaded with D;
  - all seven other lanes are loaded with 0.
- Disabled (E=0): at each rising edge all lanes are loaded with 0, regardless of D and S.
- D=0 with E=1: all lanes are 0. The selected lane is written with 0, so there is no hold of previous values.
- No state beyond the output register. Each cycle fully overwrites I, so stale lanes never persist after a change of S.
- S is always valid (3 bits, 8 lanes), so there is no out-of-range case.
- X on inputs is not specified. A bench must drive D, S and E to known values before the first active edge after reset.
- Reset asserted mid-operation: I clears asynchronously in the same delta. Any sampled-but-unregistered inputs are discarded.
- No handshake and no backpressure. The block accepts new inputs every cycle.

Decomposition:
- Shared package demux_pkg:
  - constants N_OUT=8 and SEL_W=3;
  - typedef sel_t (logic [SEL_W-1:0]).
- One sub-module, dec3to8: combinational binary-to-one-hot decoder with enable. Ports: sel[2:0], en, onehot[7:0]; onehot = en ? (1<<sel) : 0.
- Top-level composition:
  - AND/replicate D into each lane using onehot;
  - register the result with async active-low reset.

Test Plan:
- Reset: hold rst_n=0 with E=1, D=1, S=5, clocking → I=8'h00 throughout. After release, I=8'h20 one edge later.
- Disabled: E=0, S=0, D=1 for 2 cycles → I=8'h00.
- Sweep: E=1, D=1, S stepping 0..7 one per cycle → I follows 8'h01, 02, 04, 08, 10, 20, 40, 80, each one cycle after its S value is applied. Exactly one bit is set each cycle.
- Zero data: E=1, D=0, S=3 after I=8'h08 → next edge I=8'h00.
- Enable drop: E=1, D=1, S=7 (I=8'h80), then E=0 → next edge I=8'h00. Re-raise E → I=8'h80 one edge later.
- Async reset mid-stream: during the sweep at S=4, pulse rst_n low between clock edges → I=8'h00 immediately, without waiting for a clk edge. After release, the next edge restores 1<<S.
